// File: rtl/ring_host_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ring_host_pkg                                                        |
// | Shared constants, FSM state encoding and phase helper for ring_host. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ring_host_pkg;

   localparam int WORD_COUNT    = 16;
   localparam int BITS_PER_WORD = 8;
   localparam int BIT_IDX_W     = 3;
   localparam int FRAME_W       = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_WAIT  = 2'd1,
      WR_SHIFT = 2'd2,
      RD_WAIT  = 2'd3
   } state_t;

   // Frame index successor, wrapping at the ring length.
   function automatic logic [FRAME_W-1:0] frame_inc(input logic [FRAME_W-1:0] f,
                                                    input int                 wc);
      if (f == FRAME_W'(wc - 1)) return '0;
      return f + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ring_phase_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ring_phase_counter                                                   |
// | Tracks bit position within a word and the current word frame; runs   |
// | in lock-step with the attached ring device from the shared reset.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ring_phase_counter #(
   parameter int WORD_COUNT = ring_host_pkg::WORD_COUNT
) (
   input  logic                                clk,
   input  logic                                reset,
   output logic [ring_host_pkg::BIT_IDX_W-1:0] bit_idx,
   output logic [ring_host_pkg::FRAME_W-1:0]   frame
);
   import ring_host_pkg::*;

   // Bit counter free-runs; frame advances when the bit counter wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_idx <= '0;
         frame   <= '0;
      end else begin
         bit_idx <= bit_idx + 1'b1;
         if (bit_idx == BIT_IDX_W'(BITS_PER_WORD - 1)) begin
            frame <= frame_inc(frame, WORD_COUNT);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ring_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ring_host                                                            |
// | Host controller for a recirculating serial ring buffer: serialises   |
// | writes into a word's frame and captures reads from the device byte.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ring_host #(
   parameter int WORD_COUNT = ring_host_pkg::WORD_COUNT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [3:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       rd_valid,
   output logic       rd_ready,
   input  logic [3:0] rd_addr,
   output logic       rd_data_valid,
   output logic [7:0] rd_data,
   output logic       ser_write,
   output logic       ser_din,
   input  logic [7:0] dev_out,
   output logic [3:0] frame,
   output logic [2:0] bit_idx
);
   import ring_host_pkg::*;

   state_t     state;
   logic [3:0] addr_q;
   logic [7:0] data_q;
   logic [3:0] frame_next;
   logic [2:0] next_bit;
   logic       last_bit;
   logic       wr_fire;
   logic       rd_fire;
   logic       slot_next_new;
   logic       slot_next_held;
   logic       rd_hit;

   ring_phase_counter #(
      .WORD_COUNT (WORD_COUNT)
   ) u_phase (
      .clk     (clk),
      .reset   (reset),
      .bit_idx (bit_idx),
      .frame   (frame)
   );

   assign wr_ready   = (state == IDLE);
   assign rd_ready   = (state == IDLE) && !wr_valid;
   assign wr_fire    = wr_valid && wr_ready;
   assign rd_fire    = rd_valid && rd_ready;
   assign frame_next = frame_inc(frame, WORD_COUNT);
   assign next_bit   = bit_idx + 3'd1;
   assign last_bit   = (bit_idx == 3'd7);

   // ser_write/ser_din are registered, so the shift is launched one edge
   // early: the cycle before the target frame's bit 0.
   assign slot_next_new  = last_bit && (frame_next == wr_addr);
   assign slot_next_held = last_bit && (frame_next == addr_q);

   // The device presents word k on dev_out during frame k+1.
   assign rd_hit = (bit_idx == 3'd0) && (frame == frame_inc(addr_q, WORD_COUNT));

   // Request FSM with registered serial and read-completion outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         addr_q        <= '0;
         data_q        <= '0;
         ser_write     <= 1'b0;
         ser_din       <= 1'b0;
         rd_data       <= '0;
         rd_data_valid <= 1'b0;
      end else begin
         rd_data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_fire) begin
                  addr_q <= wr_addr;
                  data_q <= wr_data;
                  if (slot_next_new) begin
                     state     <= WR_SHIFT;
                     ser_write <= 1'b1;
                     ser_din   <= wr_data[7];
                  end else begin
                     state <= WR_WAIT;
                  end
               end else if (rd_fire) begin
                  addr_q <= rd_addr;
                  state  <= RD_WAIT;
               end
            end
            WR_WAIT: begin
               if (slot_next_held) begin
                  state     <= WR_SHIFT;
                  ser_write <= 1'b1;
                  ser_din   <= data_q[7];
               end
            end
            WR_SHIFT: begin
               if (last_bit) begin
                  state     <= IDLE;
                  ser_write <= 1'b0;
                  ser_din   <= 1'b0;
               end else begin
                  // MSB first: bit position b carries data bit 7-b (= ~b).
                  ser_din <= data_q[~next_bit];
               end
            end
            RD_WAIT: begin
               if (rd_hit) begin
                  rd_data       <= dev_out;
                  rd_data_valid <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ring_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ring_host                                                         |
// | Directed bench for ring_host with a cycle-accurate ring device model |
// | and a scoreboard queue of expected read bytes.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ring_host;

   localparam int WC = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [3:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       rd_valid = 1'b0;
   logic       rd_ready;
   logic [3:0] rd_addr = '0;
   logic       rd_data_valid;
   logic [7:0] rd_data;
   logic       ser_write;
   logic       ser_din;
   logic [7:0] dev_out;
   logic [3:0] frame;
   logic [2:0] bit_idx;

   ring_host #(.WORD_COUNT(WC)) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_addr       (rd_addr),
      .rd_data_valid (rd_data_valid),
      .rd_data       (rd_data),
      .ser_write     (ser_write),
      .ser_din       (ser_din),
      .dev_out       (dev_out),
      .frame         (frame),
      .bit_idx       (bit_idx)
   );

   always #5 clk = ~clk;

   // Ring device model: own phase counters, shift-in of written frames,
   // recirculation of untouched words, dev_out updated at each frame end.
   logic [7:0] mem [WC];
   logic [2:0] m_bit;
   logic [3:0] m_frame;
   logic [7:0] sh;
   logic [7:0] dev_byte;

   always_comb dev_byte = ser_write ? {sh[6:0], ser_din} : mem[m_frame];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_bit   <= '0;
         m_frame <= '0;
         sh      <= '0;
         dev_out <= '0;
         for (int i = 0; i < WC; i++) mem[i] <= '0;
      end else begin
         m_bit <= m_bit + 3'd1;
         if (m_bit == 3'd7) m_frame <= (m_frame == 4'(WC - 1)) ? 4'd0 : m_frame + 4'd1;
         if (ser_write) sh <= {sh[6:0], ser_din};
         if (m_bit == 3'd7) begin
            mem[m_frame] <= dev_byte;
            dev_out      <= dev_byte;
         end
      end
   end

   int pulses = 0;
   always @(negedge clk) if (rd_data_valid === 1'b1) pulses <= pulses + 1;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q [$];
   logic [7:0] exp_mem [WC];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (wr_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle_timeout"}, 32'(n >= 400), 32'd0);
   endtask

   task automatic wait_phase(input int f, input int b);
      int n = 0;
      while (!(int'(m_frame) == f && int'(m_bit) == b) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("phase_align_timeout", 32'(n >= 200), 32'd0);
   endtask

   function automatic int ring_dist(input int target, input int pos);
      int d;
      d = ((target - pos) % (8 * WC) + 8 * WC) % (8 * WC);
      if (d == 0) d = 8 * WC;
      return d;
   endfunction

   // Issue a write and watch the serial stream until the host is ready again.
   task automatic write_op(input logic [3:0] a, input logic [7:0] d, output int start_lat);
      int n, sw, bad_frame, bad_bit, bad_idle, exp_start;
      string t;
      t = $sformatf("wr_a%0d", a);
      wait_idle(t);
      exp_start = ring_dist(int'(a) * 8, int'(m_frame) * 8 + int'(m_bit));
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
      n = 1; sw = 0; bad_frame = 0; bad_bit = 0; bad_idle = 0; start_lat = -1;
      while (wr_ready !== 1'b1 && n < 400) begin
         if (ser_write === 1'b1) begin
            if (start_lat < 0) start_lat = n;
            sw++;
            if (frame !== a) bad_frame++;
            if (ser_din !== d[7 - int'(bit_idx)]) bad_bit++;
         end else if (ser_din !== 1'b0) begin
            bad_idle++;
         end
         @(negedge clk);
         n++;
      end
      exp_mem[a] = d;
      check({t, "_timeout"},     32'(n >= 400),    32'd0);
      check({t, "_start_lat"},   32'(start_lat),   32'(exp_start));
      check({t, "_shift_cnt"},   32'(sw),          32'd8);
      check({t, "_frame_ok"},    32'(bad_frame),   32'd0);
      check({t, "_bits_ok"},     32'(bad_bit),     32'd0);
      check({t, "_din_idle0"},   32'(bad_idle),    32'd0);
      check({t, "_ready_after"}, 32'(n),           32'(start_lat + 8));
   endtask

   // Issue a read, push the expected byte, then pop and compare on completion.
   task automatic read_op(input logic [3:0] a);
      int         n, exp_lat;
      logic [7:0] got;
      string      t;
      t = $sformatf("rd_a%0d", a);
      wait_idle(t);
      check({t, "_rd_ready"}, 32'(rd_ready), 32'd1);
      exp_lat = ring_dist(((int'(a) + 1) % WC) * 8, int'(m_frame) * 8 + int'(m_bit)) + 1;
      rd_valid = 1'b1;
      rd_addr  = a;
      exp_q.push_back(exp_mem[a]);
      @(negedge clk);
      rd_valid = 1'b0;
      n = 1;
      while (rd_data_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({t, "_timeout"}, 32'(n >= 300), 32'd0);
      check({t, "_latency"}, 32'(n), 32'(exp_lat));
      got = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check({t, "_data"}, 32'(rd_data), 32'(got));
      @(negedge clk);
      check({t, "_pulse_end"}, 32'(rd_data_valid), 32'd0);
      check({t, "_data_hold"}, 32'(rd_data), 32'(got));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n, p0;
      for (int i = 0; i < WC; i++) exp_mem[i] = 8'h00;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      check("rst_rd_ready", 32'(rd_ready), 32'd1);
      check("rst_ser_write", 32'(ser_write), 32'd0);
      check("rst_ser_din", 32'(ser_din), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'h00);
      check("rst_rd_valid", 32'(rd_data_valid), 32'd0);
      check("rst_frame", 32'(frame), 32'd0);
      check("rst_bit_idx", 32'(bit_idx), 32'd0);
      reset = 1'b0;

      // Single write, MSB-first serial stream in frame 3.
      write_op(4'd3, 8'hA5, lat);
      check("phase_frame_sync", 32'(frame), 32'(m_frame));
      check("phase_bit_sync", 32'(bit_idx), 32'(m_bit));

      // Write then read back the same word.
      write_op(4'd5, 8'h3C, lat);
      read_op(4'd5);

      // Simultaneous write and read: write wins, read follows.
      wait_idle("both");
      wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 8'h5A;
      rd_valid = 1'b1; rd_addr = 4'd9;
      #1;
      check("both_rd_ready_low", 32'(rd_ready), 32'd0);
      check("both_wr_ready_high", 32'(wr_ready), 32'd1);
      @(negedge clk);
      wr_valid = 1'b0;
      check("both_busy_rd_ready", 32'(rd_ready), 32'd0);
      exp_mem[9] = 8'h5A;
      n = 0;
      while (wr_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("both_wr_timeout", 32'(n >= 400), 32'd0);
      check("both_rd_ready_after", 32'(rd_ready), 32'd1);
      exp_q.push_back(exp_mem[9]);
      @(negedge clk);
      rd_valid = 1'b0;
      n = 0;
      while (rd_data_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("both_rd_timeout", 32'(n >= 300), 32'd0);
      check("both_rd_data", 32'(rd_data), 32'(exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx));

      // Slot beginning in the acceptance cycle waits a full revolution.
      wait_idle("rev");
      wait_phase(2, 0);
      write_op(4'd2, 8'hC3, lat);
      check("rev_start_128", 32'(lat), 32'd128);

      // Acceptance just before the slot starts shifting on the next cycle.
      wait_idle("near");
      wait_phase(6, 7);
      write_op(4'd7, 8'h81, lat);
      check("near_start_1", 32'(lat), 32'd1);

      // Fill every word, read back in reverse order.
      for (int k = 0; k < WC; k++) write_op(4'(k), 8'(8'h10 + k), lat);
      for (int k = WC - 1; k >= 0; k--) read_op(4'(k));

      // Reset during the shift of bit 4 aborts cleanly.
      wait_idle("abort");
      wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 8'hFF;
      @(negedge clk);
      wr_valid = 1'b0;
      n = 0;
      while (!(ser_write === 1'b1 && bit_idx == 3'd4) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("abort_reach_bit4", 32'(n >= 300), 32'd0);
      p0 = pulses;
      reset = 1'b1;
      #1;
      check("abort_ser_write", 32'(ser_write), 32'd0);
      check("abort_ser_din", 32'(ser_din), 32'd0);
      check("abort_wr_ready", 32'(wr_ready), 32'd1);
      check("abort_frame", 32'(frame), 32'd0);
      check("abort_bit_idx", 32'(bit_idx), 32'd0);
      check("abort_rd_data", 32'(rd_data), 32'h00);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_no_pulse", 32'(pulses), 32'(p0));
      check("abort_rd_valid", 32'(rd_data_valid), 32'd0);

      // Recovery after reset.
      write_op(4'd4, 8'h77, lat);
      read_op(4'd4);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ring_host.md
RING_HOST -- requirements
Module: ring_host

Interface
REQ-001 Parameter: WORD_COUNT, default 16, number of 8-bit words in the attached serial ring buffer.
REQ-002 clk  input  1  clock; rising-edge active; also drives the attached ring device.
REQ-003 reset  input  1  reset, asynchronous, active-high; also drives the attached ring device.
REQ-004 wr_valid / wr_ready  input / output  1 / 1  write request handshake.
REQ-005 wr_addr / wr_data  input  4 / 8  target word index / byte to store.
REQ-006 rd_valid / rd_ready  input / output  1 / 1  read request handshake.
REQ-007 rd_addr  input  4  word index to read.
REQ-008 rd_data_valid / rd_data  output  1 / 8  one-cycle read-completion pulse / captured byte.
REQ-009 ser_write / ser_din  output  1 / 1  device write strobe / device serial data.
REQ-010 dev_out  input  8  device parallel byte output, updated by the device at the edge ending each 8-cycle frame.
REQ-011 frame / bit_idx  output  4 / 3  current ring phase, for debug.

Function
REQ-012 bit_idx increments every cycle, wrapping 7->0; frame increments when bit_idx wraps, wrapping (WORD_COUNT-1)->0; both mirror device phase exactly.
REQ-013 Word k is the byte transferred during the 8 cycles with frame==k; it recirculates every 8*WORD_COUNT cycles.
REQ-014 FSM states: IDLE, WR_WAIT, WR_SHIFT, RD_WAIT; one operation in flight at a time.
REQ-015 wr_ready = (state==IDLE); rd_ready = (state==IDLE) and not wr_valid; write wins when both valid.
REQ-016 Write accepted at edge with wr_valid&&wr_ready: latch addr/data, go to WR_WAIT.
REQ-017 WR_WAIT -> WR_SHIFT at the first frame==wr_addr, bit_idx==0 cycle strictly after acceptance.
REQ-018 In WR_SHIFT: ser_write=1 for exactly the 8 cycles bit_idx 0..7 of that frame; ser_din = wr_data[7-bit_idx] (MSB first); return to IDLE after bit_idx==7.
REQ-019 ser_write=0 and ser_din=0 in every cycle not covered by REQ-018.
REQ-020 Read accepted at edge with rd_valid&&rd_ready: latch addr, go to RD_WAIT.
REQ-021 In RD_WAIT, at the first cycle strictly after acceptance with bit_idx==0 and frame==(rd_addr+1) mod WORD_COUNT, register dev_out into rd_data; assert rd_data_valid the following cycle for exactly one cycle; return to IDLE.
REQ-022 rd_data holds its value until the next capture.
REQ-023 Worst-case latency, acceptance to completion: write 8*WORD_COUNT+8 cycles; read 8*WORD_COUNT+1 cycles.
REQ-024 Request for an address whose slot begins in the acceptance cycle waits one full revolution.
REQ-025 Read of word k issued after a completed write of word k returns the written byte.
REQ-026 Requests arriving while busy are held off (ready low); no queuing.

Reset
REQ-027 On reset: state=IDLE, bit_idx=0, frame=0, ser_write=0, ser_din=0, rd_data=0x00, rd_data_valid=0, latched addr/data=0.
REQ-028 Reset mid-operation aborts it with no completion pulse; the device-side word contents are undefined thereafter.
REQ-029 Reset must be shared with the device so both phase counters restart at 0 on the same edge.

Structure
REQ-030 Package ring_host_pkg holds WORD_COUNT, BITS_PER_WORD=8, the FSM state enum and phase-counter widths.
REQ-031 Sub-module ring_phase_counter implements bit_idx/frame (REQ-012); ring_host instantiates it once.

Verification
REQ-032 Reset, write addr 3 data 0xA5 -> ser_write high in exactly frame 3 cycles 0..7, ser_din 1,0,1,0,0,1,0,1; wr_ready low until done.
REQ-033 Write addr 5 = 0x3C, then read addr 5 -> rd_data_valid one cycle, rd_data=0x3C, against a cycle-accurate device model.
REQ-034 Fill all 16 words with 0x10+k, read back in order 15..0 -> each returns 0x10+k.
REQ-035 wr_valid and rd_valid both high in IDLE -> write accepted, rd_ready=0 that cycle; read accepted after write completes.
REQ-036 Write addr 2 accepted when frame==2, bit_idx==0 -> shifting starts 128 cycles later.
REQ-037 Reset asserted during WR_SHIFT bit 4 -> ser_write=0 immediately, FSM IDLE, no rd_data_valid, counters 0.
